booth_mult: RTL



---
 rtl/mult_pkg.sv | 17 +
 rtl/booth_step.sv | 35 +++
 rtl/booth_mult.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and types for the booth_mult block
// Holds the default operand width, the iteration counter width, the FSM
// state type and the radix-2 Booth recode constants for {Q[0], q_m1}.
package mult_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } mult_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth iteration
// Ports:
//   acc_i, q_i, q_m1_i : current {acc, Q, q_m1} (acc is WIDTH+1 bits)
//   m_i                : sign-extended multiplicand (WIDTH+1 bits)
//   acc_o, q_o, q_m1_o : next {acc, Q, q_m1} after add/sub and arithmetic shift
module booth_step
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             q_m1_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             q_m1_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc_i;
        case ({q_i[0], q_m1_i})
            BOOTH_ADD: sum = acc_i + m_i;
            BOOTH_SUB: sum = acc_i - m_i;
            default:   sum = acc_i;
        endcase
    end

    // Arithmetic right shift of {sum, Q, q_m1}: the sign bit of the
    // accumulator is replicated and Q[0] falls into q_m1.
    assign {acc_o, q_o, q_m1_o} = {sum[WIDTH], sum, q_i};

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed WIDTHxWIDTH radix-2 Booth multiplier
// Ports:
//   clk, reset        : rising-edge clock, asynchronous active-high reset
//   mult_control      : start request, accepted only while idle
//   a_in, b_in        : signed multiplicand / multiplier, sampled at the start edge
//   hi_out, lo_out    : upper / lower half of the last completed product
//   mult_end          : one-cycle done pulse
//   busy              : operation in progress
// Optional feature macro: BOOTH_MULT_ZERO_SKIP_EN (single-cycle result when
// either operand is zero).
module booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = mult_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_control,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             mult_end,
    output logic             busy
);

    localparam int CNT_LW = $clog2(WIDTH + 1);

    mult_state_t        state_q, state_d;
    logic [CNT_LW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   qr_q, qr_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               end_q, end_d;

    logic [WIDTH:0]     step_acc;
    logic [WIDTH-1:0]   step_qr;
    logic               step_qm1;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .q_i    (qr_q),
        .q_m1_i (qm1_q),
        .m_i    (m_q),
        .acc_o  (step_acc),
        .q_o    (step_qr),
        .q_m1_o (step_qm1)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        qr_d    = qr_q;
        qm1_d   = qm1_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        end_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mult_control) begin
`ifdef BOOTH_MULT_ZERO_SKIP_EN
                    if ((a_in == '0) || (b_in == '0)) begin
                        hi_d  = '0;
                        lo_d  = '0;
                        end_d = 1'b1;
                    end else begin
                        m_d     = {a_in[WIDTH-1], a_in};
                        acc_d   = '0;
                        qr_d    = b_in;
                        qm1_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
`else
                    m_d     = {a_in[WIDTH-1], a_in};
                    acc_d   = '0;
                    qr_d    = b_in;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                acc_d = step_acc;
                qr_d  = step_qr;
                qm1_d = step_qm1;
                cnt_d = cnt_q + CNT_LW'(1);
                // This edge performs the final step, so publish the
                // post-shift value straight from the step logic.
                if (cnt_q == CNT_LW'(WIDTH - 1)) begin
                    hi_d    = step_acc[WIDTH-1:0];
                    lo_d    = step_qr;
                    end_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            qr_q    <= '0;
            qm1_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            qr_q    <= qr_d;
            qm1_q   <= qm1_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            end_q   <= end_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign mult_end = end_q;
    assign busy     = (state_q == RUN);

endmodule
